// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time and period of an external PWM waveform
// in clk cycles. It reports each measurement as a control word plus a period,
// and flags loss of signal when the line is stuck high or low.
//
// Ports:
//   clk         - system clock, all logic on posedge
//   reset       - synchronous active-high reset
//   pwm_in      - external PWM input, asynchronous to clk
//   duty_cw     - measured high time (WIDTH bits, saturates at all ones)
//   period_cw   - measured period, rise to rise (WIDTH+1 bits)
//   cw_valid    - one-cycle strobe when duty_cw/period_cw are updated
//   signal_lost - sticky; set on timeout, cleared by the next good measurement
module pwm_capture #(
  parameter int unsigned WIDTH   = 17,
  parameter int unsigned TIMEOUT = 262143
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty_cw,
  output logic [WIDTH:0]   period_cw,
  output logic             cw_valid,
  output logic             signal_lost
);

  localparam logic [WIDTH:0]   CntMax     = (WIDTH+1)'(TIMEOUT);
  localparam logic [WIDTH:0]   CntLimit   = (WIDTH+1)'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] DutyMax    = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   DutyMaxExt = {1'b0, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH:0]   period_q, period_d;
  logic             valid_q, valid_d;
  logic             lost_q, lost_d;

  logic             rise, fall, timeout;
  logic [WIDTH:0]   cnt_inc;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  // Counter never wraps; it parks at TIMEOUT.
  assign cnt_inc = (cnt_q >= CntMax) ? CntMax : cnt_q + 1'b1;

  // >= rather than == so a fall exactly at the limit cannot leave LOW without
  // a timeout once the counter has parked beyond the limit.
  assign timeout = (cnt_q >= CntLimit);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      high_cnt_q <= '0;
      duty_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      s1_q       <= pwm_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_cnt_q <= high_cnt_d;
      duty_q     <= duty_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      lost_q     <= lost_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_cnt_d = high_cnt_q;
    duty_d     = duty_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    lost_d     = lost_q;

    unique case (state_q)
      StIdle: begin
        // The partial period seen on entry is discarded; no timeout here.
        if (rise) begin
          state_d = StHigh;
          cnt_d   = '0;
        end
      end
      StHigh: begin
        cnt_d = cnt_inc;
        if (fall) begin
          high_cnt_d = (cnt_inc > DutyMaxExt) ? DutyMax : cnt_inc[WIDTH-1:0];
          state_d    = StLow;
        end else if (timeout) begin
          duty_d   = DutyMax;
          period_d = '0;
          lost_d   = 1'b1;
          valid_d  = 1'b1;
          state_d  = StIdle;
        end
      end
      StLow: begin
        // An edge on the limit cycle wins over the timeout.
        if (rise) begin
          duty_d   = high_cnt_q;
          period_d = cnt_inc;
          lost_d   = 1'b0;
          valid_d  = 1'b1;
          cnt_d    = '0;
          state_d  = StHigh;
        end else if (timeout) begin
          duty_d   = '0;
          period_d = '0;
          lost_d   = 1'b1;
          valid_d  = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign duty_cw     = duty_q;
  assign period_cw   = period_q;
  assign cw_valid    = valid_q;
  assign signal_lost = lost_q;

endmodule
